// File: rtl/prbs_checker_mc.sv
// Multi-lane PRBS checker: per-lane SEED -> VERIFY -> LOCKED with saturating error/bit counters,
// plus sticky err_limit_hit and sim_done. Define PRBS_CHK_ERR_STOP_EN to let err_limit_hit end the run.
module prbs_checker_mc #(
    parameter int N_LANES    = 2,
    parameter int PRBS_ORDER = 7,
    parameter int LOCK_LEN   = 32,
    parameter int LOSS_LEN   = 8,
    parameter int ERR_W      = 16,
    parameter int CNT_W      = 32,
    parameter int TIME_W     = 32,
    parameter int ERR_LIMIT  = 100
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic [N_LANES-1:0]       data_in,
    input  logic [N_LANES-1:0]       data_valid,
    input  logic [TIME_W-1:0]        time_curr,
    input  logic [TIME_W-1:0]        time_stop,
    output logic [N_LANES-1:0]       locked,
    output logic [N_LANES*ERR_W-1:0] err_count,
    output logic [N_LANES*CNT_W-1:0] bit_count,
    output logic                     err_limit_hit,
    output logic                     sim_done
);

    // Second feedback tap: x^7+x^6+1, x^15+x^14+1, x^31+x^28+1.
    localparam int TAP_B   = (PRBS_ORDER == 31) ? 27 : (PRBS_ORDER == 15) ? 13 : 5;
    localparam int SEED_W  = $clog2(PRBS_ORDER + 1);
    localparam int MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int MISS_W  = $clog2(LOSS_LEN + 1);
    localparam int SUM_W   = ERR_W + $clog2(N_LANES);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        state_t                state;
        logic [PRBS_ORDER-1:0] lfsr;
        logic [SEED_W-1:0]     seed_cnt;
        logic [MATCH_W-1:0]    match_cnt;
        logic [MISS_W-1:0]     miss_cnt;
        logic                  lock_q;
        logic [ERR_W-1:0]      err_q;
        logic [CNT_W-1:0]      bits_q;
        logic                  bit_in;
        logic                  pred;

        assign bit_in = data_in[i];
        assign pred   = lfsr[PRBS_ORDER-1] ^ lfsr[TAP_B];

        // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
        always_ff @(posedge clk_sys) begin
            if (rst) begin
                state     <= SEED;
                lfsr      <= '0;
                seed_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                lock_q    <= 1'b0;
                err_q     <= '0;
                bits_q    <= '0;
            end else if (data_valid[i]) begin
                unique case (state)
                    SEED: begin
                        lfsr <= {lfsr[PRBS_ORDER-2:0], bit_in};
                        if (seed_cnt == SEED_W'(PRBS_ORDER - 1)) begin
                            state     <= VERIFY;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            seed_cnt <= seed_cnt + SEED_W'(1);
                        end
                    end
                    VERIFY: begin
                        lfsr <= {lfsr[PRBS_ORDER-2:0], pred};
                        if (bit_in == pred) begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                            if (match_cnt == MATCH_W'(LOCK_LEN - 1)) begin
                                state    <= LOCKED;
                                lock_q   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state     <= SEED;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Self-running reference: received errors never feed back into the LFSR.
                        lfsr <= {lfsr[PRBS_ORDER-2:0], pred};
                        if (bits_q != '1) bits_q <= bits_q + CNT_W'(1);
                        if (bit_in != pred) begin
                            if (err_q != '1) err_q <= err_q + ERR_W'(1);
                            if (miss_cnt == MISS_W'(LOSS_LEN - 1)) begin
                                state    <= SEED;
                                lock_q   <= 1'b0;
                                miss_cnt <= '0;
                                seed_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= SEED;
                endcase
            end
        end

        assign locked[i]                    = lock_q;
        assign err_count[i*ERR_W +: ERR_W]  = err_q;
        assign bit_count[i*CNT_W +: CNT_W]  = bits_q;
    end

    logic [SUM_W-1:0] err_sum;
    logic             limit_reached;

    // NOTE: combinational blocks use blocking assignments and assign a default first, so no latch is inferred.
    always_comb begin
        err_sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            err_sum = err_sum + SUM_W'(err_count[i*ERR_W +: ERR_W]);
        end
    end

    assign limit_reached = (64'(err_sum) >= 64'(ERR_LIMIT));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            err_limit_hit <= 1'b0;
            sim_done      <= 1'b0;
        end else begin
            if (limit_reached) err_limit_hit <= 1'b1;
            if (time_curr >= time_stop) sim_done <= 1'b1;
`ifdef PRBS_CHK_ERR_STOP_EN
            if (err_limit_hit) sim_done <= 1'b1;
`else
`endif
        end
    end

endmodule

// File: tb/tb_prbs_checker_mc.sv
// Self-checking bench for prbs_checker_mc: a queue-based model of the lane rules is compared every
// cycle, plus literal checkpoints for lock timing, error counts, loss/relock, early stop and time stop.
module tb_prbs_checker_mc;

    localparam int N         = 2;
    localparam int ORDER     = 7;
    localparam int TAP_M     = 6;     // b[n] = b[n-7] ^ b[n-6]
    localparam int LOCK_LEN  = 32;
    localparam int LOSS_LEN  = 8;
    localparam int ERR_W     = 8;
    localparam int CNT_W     = 9;
    localparam int TIME_W    = 32;
    localparam int ERR_LIMIT = 100;
    localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`ifdef PRBS_CHK_ERR_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic                 clk_sys = 1'b0;
    logic                 rst;
    logic [N-1:0]         data_in;
    logic [N-1:0]         data_valid;
    logic [TIME_W-1:0]    time_curr;
    logic [TIME_W-1:0]    time_stop;
    logic [N-1:0]         locked;
    logic [N*ERR_W-1:0]   err_count;
    logic [N*CNT_W-1:0]   bit_count;
    logic                 err_limit_hit;
    logic                 sim_done;

    prbs_checker_mc #(
        .N_LANES(N), .PRBS_ORDER(ORDER), .LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN),
        .ERR_W(ERR_W), .CNT_W(CNT_W), .TIME_W(TIME_W), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .time_curr(time_curr), .time_stop(time_stop), .locked(locked),
        .err_count(err_count), .bit_count(bit_count),
        .err_limit_hit(err_limit_hit), .sim_done(sim_done)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (mode: 0 seed, 1 verify, 2 locked) ----------------
    int     m_mode   [N];
    int     m_seeded [N];
    int     m_match  [N];
    int     m_miss   [N];
    longint m_err    [N];
    longint m_bits   [N];
    bit     m_hist   [N][$];   // last ORDER reference bits, oldest first
    bit     m_hit;
    bit     m_done;
    bit     check_en = 1'b0;

    function automatic void model_reset();
        for (int l = 0; l < N; l++) begin
            m_mode[l] = 0; m_seeded[l] = 0; m_match[l] = 0; m_miss[l] = 0;
            m_err[l] = 0; m_bits[l] = 0;
            m_hist[l].delete();
        end
        m_hit  = 1'b0;
        m_done = 1'b0;
    endfunction

    function automatic void model_step(input int l, input bit d);
        bit p;
        if (m_mode[l] == 0) begin
            m_hist[l].push_back(d);
            if (m_hist[l].size() > ORDER) void'(m_hist[l].pop_front());
            m_seeded[l]++;
            if (m_seeded[l] == ORDER) begin
                m_mode[l]  = 1;
                m_match[l] = 0;
            end
        end else begin
            p = m_hist[l][0] ^ m_hist[l][ORDER-TAP_M];
            m_hist[l].push_back(p);
            void'(m_hist[l].pop_front());
            if (m_mode[l] == 1) begin
                if (d == p) begin
                    m_match[l]++;
                    if (m_match[l] == LOCK_LEN) begin
                        m_mode[l] = 2;
                        m_miss[l] = 0;
                    end
                end else begin
                    m_mode[l]   = 0;
                    m_seeded[l] = 0;
                end
            end else begin
                if (m_bits[l] < CNT_MAX) m_bits[l]++;
                if (d != p) begin
                    if (m_err[l] < ERR_MAX) m_err[l]++;
                    m_miss[l]++;
                    if (m_miss[l] == LOSS_LEN) begin
                        m_mode[l]   = 0;
                        m_seeded[l] = 0;
                        m_miss[l]   = 0;
                    end
                end else begin
                    m_miss[l] = 0;
                end
            end
        end
    endfunction

    always @(posedge clk_sys) begin
        bit     nh;
        bit     nd;
        longint sum;
        if (rst) begin
            model_reset();
        end else begin
            sum = 0;
            for (int l = 0; l < N; l++) sum += m_err[l];
            nh = m_hit | (sum >= ERR_LIMIT);
            nd = m_done | (time_curr >= time_stop) | (STOP_EN & m_hit);
            for (int l = 0; l < N; l++) begin
                if (data_valid[l]) model_step(l, data_in[l]);
            end
            m_hit  = nh;
            m_done = nd;
        end
    end

    always @(negedge clk_sys) begin
        if (check_en) begin
            for (int l = 0; l < N; l++) begin
                check($sformatf("model locked[%0d]", l), locked[l], m_mode[l] == 2);
                check($sformatf("model err_count[%0d]", l), err_count[l*ERR_W +: ERR_W], m_err[l]);
                check($sformatf("model bit_count[%0d]", l), bit_count[l*CNT_W +: CNT_W], m_bits[l]);
            end
            check("model err_limit_hit", err_limit_hit, m_hit);
            check("model sim_done", sim_done, m_done);
        end
    end

    // ---------------- stimulus: per-lane PRBS generators ----------------
    bit g_hist [N][$];

    function automatic void gen_seed();
        for (int l = 0; l < N; l++) begin
            g_hist[l].delete();
            for (int k = 0; k < ORDER; k++) g_hist[l].push_back(1'($urandom));
            g_hist[l][ORDER-1] = 1'b1;   // never the all-zero state
        end
    endfunction

    function automatic bit gen_next(input int l);
        bit b;
        b = g_hist[l][0] ^ g_hist[l][ORDER-TAP_M];
        g_hist[l].push_back(b);
        void'(g_hist[l].pop_front());
        return b;
    endfunction

    // Apply inputs at a falling edge, then wait until the next falling edge.
    task automatic step(input bit [N-1:0] v, input bit [N-1:0] flip);
        for (int l = 0; l < N; l++) begin
            if (v[l]) data_in[l] = gen_next(l) ^ flip[l];
            else      data_in[l] = 1'($urandom);
        end
        data_valid = v;
        @(negedge clk_sys);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step('0, '0);
        rst = 1'b0;
        gen_seed();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int burst [N];
        rst = 1'b1; data_in = '0; data_valid = '0; time_curr = '0; time_stop = 1000;
        gen_seed();
        @(negedge clk_sys);
        repeat (2) step('0, '0);
        check("reset locked", locked, 0);
        check("reset err_count", err_count, 0);
        check("reset bit_count", bit_count, 0);
        check("reset err_limit_hit", err_limit_hit, 0);
        check("reset sim_done", sim_done, 0);
        check_en = 1'b1;
        rst = 1'b0;

        // Clean lock: 7 seed bits + 32 matches.
        repeat (38) step('1, '0);
        check("locked after 38 valid", locked, 0);
        step('1, '0);
        check("locked after 39 valid", locked, 2'b11);
        check("bit_count at lock edge", bit_count, 0);
        repeat (10) step('1, '0);
        check("bit_count lane0 after 10", bit_count[0 +: CNT_W], 10);
        check("err_count clean", err_count, 0);

        // Five isolated flips on lane 0.
        for (int k = 0; k < 5; k++) begin
            step('1, 2'b01);
            repeat (3) step('1, '0);
        end
        check("single flips err lane0", err_count[0 +: ERR_W], 5);
        check("single flips err lane1", err_count[ERR_W +: ERR_W], 0);
        check("single flips locked", locked, 2'b11);

        // Loss on lane 1 after 8 consecutive misses, then relock 39 valid cycles later.
        repeat (7) step('1, 2'b10);
        check("lane1 locked after 7 misses", locked[1], 1);
        step('1, 2'b10);
        check("lane1 locked after 8 misses", locked[1], 0);
        check("lane1 err after loss", err_count[ERR_W +: ERR_W], 8);
        repeat (38) step('1, '0);
        check("lane1 relock after 38", locked[1], 0);
        step('1, '0);
        check("lane1 relock after 39", locked[1], 1);
        check("lane1 err retained", err_count[ERR_W +: ERR_W], 8);

        // Gapped valid: 0101..., 39th valid bit lands on cycle 78.
        do_reset();
        for (int k = 0; k < 78; k++) begin
            step((k % 2 == 1) ? 2'b11 : 2'b00, '0);
            if (k == 76) check("gapped locked after 77", locked, 0);
        end
        check("gapped locked after 78", locked, 2'b11);

        // Randomized traffic: random valid, random flips, occasional loss bursts on lane 1.
        do_reset();
        for (int l = 0; l < N; l++) burst[l] = 0;
        for (int k = 0; k < 2000; k++) begin
            bit [N-1:0] v;
            bit [N-1:0] f;
            for (int l = 0; l < N; l++) begin
                v[l] = ($urandom_range(0, 99) < 75);
                if (burst[l] > 0) begin
                    f[l] = 1'b1;
                    burst[l]--;
                end else if (m_mode[l] == 2) begin
                    f[l] = ($urandom_range(0, 999) < ((l == 0) ? 300 : 20));
                end else begin
                    f[l] = ($urandom_range(0, 999) < 10);
                end
            end
            if ($urandom_range(0, 299) == 0) burst[1] = $urandom_range(8, 12);
            time_curr = $urandom_range(0, 999);
            step(v, f);
        end
        check("lane0 err_count saturated", err_count[0 +: ERR_W], ERR_MAX);
        check("lane0 bit_count saturated", bit_count[0 +: CNT_W], CNT_MAX);

        // Early stop: 60 + 40 isolated errors.
        time_curr = 0;
        do_reset();
        repeat (39) step('1, '0);
        check("early stop locked", locked, 2'b11);
        for (int k = 0; k < 60; k++) begin
            step('1, 2'b01);
            repeat (3) step('1, '0);
        end
        for (int k = 0; k < 39; k++) begin
            step('1, 2'b10);
            repeat (3) step('1, '0);
        end
        step('1, 2'b10);
        check("early stop err lane0", err_count[0 +: ERR_W], 60);
        check("early stop err lane1", err_count[ERR_W +: ERR_W], 40);
        check("err_limit_hit same edge", err_limit_hit, 0);
        step('1, '0);
        check("err_limit_hit next edge", err_limit_hit, 1);
        check("sim_done with hit edge", sim_done, 0);
        step('1, '0);
        check("sim_done after hit", sim_done, STOP_EN);

        // Reset mid-check overrides valid data.
        rst = 1'b1;
        step('1, '1);
        rst = 1'b0;
        check("mid rst locked", locked, 0);
        check("mid rst err_count", err_count, 0);
        check("mid rst bit_count", bit_count, 0);
        check("mid rst err_limit_hit", err_limit_hit, 0);
        check("mid rst sim_done", sim_done, 0);

        // Time stop at 1000.
        time_stop = 1000;
        for (int t = 995; t < 1000; t++) begin
            time_curr = t;
            step('1, '0);
            check("sim_done before stop", sim_done, 0);
        end
        time_curr = 1000;
        step('1, '0);
        check("sim_done at stop", sim_done, 1);
        time_curr = 0;
        step('1, '0);
        check("sim_done sticky", sim_done, 1);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker_mc.md
# prbs_checker_mc

Multi-lane PRBS checker and simulation-termination controller for the link emulator. Per lane, it seeds a local LFSR from the received bitstream, verifies and declares lock, then counts bit errors and checked bits against the self-running reference. It replaces the single `time_curr >= TIME_STOP` monitor with a sticky `sim_done` that can also fire on an aggregate error limit. It sits after the RX slicers, in the `clk_sys` domain, one instance per link group.

## Interface

Parameters:
- N_LANES, 2, number of independent lanes
- PRBS_ORDER, 7, LFSR order; supported values are 7 (x^7+x^6+1), 15 (x^15+x^14+1) and 31 (x^31+x^28+1)
- LOCK_LEN, 32, consecutive matching bits required to declare lock
- LOSS_LEN, 8, consecutive mismatching bits in LOCKED that drop lock
- ERR_W, 16, per-lane error counter width (saturating)
- CNT_W, 32, per-lane checked-bit counter width (saturating)
- TIME_W, 32, width of the time inputs
- ERR_LIMIT, 100, aggregate error threshold for early stop

Ports:
- clk_sys  in  1  system clock; the block has this single clock
- rst  in  1  synchronous, active-high reset
- data_in  in  N_LANES  received bit per lane
- data_valid  in  N_LANES  per-lane strobe; `data_in[i]` is consumed only when `data_valid[i]` is high
- time_curr  in  TIME_W  current emulated time
- time_stop  in  TIME_W  stop time
- locked  out  N_LANES  per-lane lock flag
- err_count  out  N_LANES*ERR_W  packed per-lane error counts; lane i occupies `[i*ERR_W +: ERR_W]`
- bit_count  out  N_LANES*CNT_W  packed per-lane counts of checked bits
- err_limit_hit  out  1  sticky; aggregate error limit reached
- sim_done  out  1  sticky; simulation complete

## Operation

Each lane runs an independent FSM: SEED → VERIFY → LOCKED. All transitions occur only on cycles where that lane's `data_valid` is high.

- **SEED**
  - Shift `data_in` into the lane LFSR.
  - After PRBS_ORDER valid bits, go to VERIFY with the match counter at 0.
- **VERIFY**
  - Predicted bit is computed from the LFSR taps. The LFSR advances using its own predicted bit.
  - Match: increment the match counter. When it reaches LOCK_LEN, go to LOCKED.
  - Mismatch: return to SEED, clearing the seed bit count and the match counter.
  - `err_count` and `bit_count` do not change in this state.
- **LOCKED**
  - The LFSR is self-running, so input errors never corrupt the reference.
  - Every valid bit increments `bit_count`.
  - A mismatch increments `err_count` and the consecutive-miss counter. A match clears the consecutive-miss counter.
  - When the consecutive-miss counter reaches LOSS_LEN, go to SEED. The counters are retained, not cleared.
- **Counters:** both saturate at all-ones and never wrap.
- **Aggregate errors:** the sum of all lane `err_count` values, computed at width ERR_W + ceil(log2(N_LANES)) with no overflow.
- **err_limit_hit:** set when the aggregate is ≥ ERR_LIMIT; stays high until reset.
- **sim_done:** set when `time_curr >= time_stop` (unsigned compare). With the macro in Configuration enabled, it is also set by `err_limit_hit`. Sticky until `rst`.
- **Lane independence:** no lane's state affects another lane.

## Timing

- **Reset values:** all outputs are 0 (`locked`, `err_count`, `bit_count`, `err_limit_hit`, `sim_done`). Every FSM is in SEED, and every LFSR and internal counter is 0.
- **rst mid-operation:** synchronous. It overrides any simultaneous valid bit and returns the block to the reset state on the next edge.
- **Output registers:** all outputs are registered.
  - `locked[i]` rises on the edge that consumes the LOCK_LEN-th match.
  - `locked[i]` falls on the edge that consumes the LOSS_LEN-th consecutive miss.
- **Counter latency:** counters update on the same edge that consumes the bit.
- **Minimum lock time:** PRBS_ORDER + LOCK_LEN valid cycles from reset.
- **err_limit_hit latency:** rises one cycle after the `err_count` update that crosses ERR_LIMIT.
- **sim_done latency:**
  - One cycle after `time_curr >= time_stop` is first sampled.
  - One cycle after `err_limit_hit` rises, when the early-stop feature is enabled.
- **Simultaneous events:** time-stop and error-limit in the same cycle produce a single assertion of `sim_done`.
- **data_valid low:** the lane holds all state.

## Configuration

- **Macro:** `PRBS_CHK_ERR_STOP_EN`
  - **Defined:** `sim_done` is the OR of the time-stop condition and `err_limit_hit`.
  - **Undefined:** `sim_done` depends only on time. `err_limit_hit` is still computed and output.

## Test plan

- **Clean lock:** reset, then drive clean PRBS7 on both lanes with `data_valid`=1 every cycle → `locked`=2'b11 exactly 39 cycles after reset release; `err_count`=0; `bit_count` increments by 1 per cycle.
- **Single flips:** after lock, flip 5 isolated bits on lane 0 → `err_count[0]`=5, `locked[0]` stays 1, lane 1 is unaffected.
- **Loss and relock:** invert 8 consecutive bits on lane 1 → `locked[1]` falls on the 8th; relock occurs 39 valid cycles later with `err_count[1]`=8 retained.
- **Gapped valid:** `data_valid` toggling 1010… → lock takes 78 cycles; state is frozen on invalid cycles.
- **Early stop:** with `PRBS_CHK_ERR_STOP_EN` and ERR_LIMIT=100, inject 60+40 errors → `err_limit_hit` and `sim_done` both 1, with `sim_done` one cycle later. Without the macro, `sim_done` stays 0 until `time_curr` reaches `time_stop`.
- **Reset and time stop:** with time_stop=1000, `sim_done` rises one cycle after time_curr=1000 is first sampled. Asserting `rst` mid-CHECK → all outputs 0 the next cycle.
